// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_pkg: RV32I opcodes, encoder request kinds and immediate range helper.
// Rev 1.0
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0]  OP_LW  = 7'b0000011;
  localparam logic [6:0]  OP_SW  = 7'b0100011;
  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_BEQ = 7'b1100011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {
    KIND_LW    = 3'd0,
    KIND_SW    = 3'd1,
    KIND_RTYPE = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_ITYPE = 3'd4,
    KIND_JAL   = 3'd5
  } enc_kind_t;

  // True when imm is representable as a signed value of the given bit width.
  function automatic logic imm_fits(input logic [31:0] imm, input int bits);
    logic signed [31:0] s;
    logic signed [31:0] lim;
    s   = $signed(imm);
    lim = 32'sd1 <<< (bits - 1);
    return (s >= -lim) && (s < lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_encode_core: combinational field-to-RV32I packer with range check.
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_encode_core
  import riscv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_ok
);

  always_comb begin
    word   = NOP;
    imm_ok = 1'b0;
    case (kind)
      KIND_LW: begin
        imm_ok = imm_fits(imm, 12);
        word   = {imm[11:0], rs1, 3'b010, rd, OP_LW};
      end
      KIND_SW: begin
        imm_ok = imm_fits(imm, 12);
        word   = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
      end
      KIND_RTYPE: begin
        imm_ok = 1'b1;
        word   = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      end
      KIND_BEQ: begin
        imm_ok = imm_fits(imm, 13) && !imm[0];
        word   = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BEQ};
      end
      KIND_ITYPE: begin
        imm_ok = imm_fits(imm, 12);
        word   = {imm[11:0], rs1, funct3, rd, OP_I};
      end
      KIND_JAL: begin
        imm_ok = imm_fits(imm, 21) && !imm[0];
        word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      default: ;
    endcase
    // Out-of-range immediates and unknown kinds both occupy their slot as a NOP.
    if (!imm_ok) word = NOP;
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_encoder_loader: streams encoded RV32I words into imem from a base addr.
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_last,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              imm_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_addr_end;
  logic [31:0]       w_word;
  logic              w_imm_ok;
  logic              w_accept;

  instr_encode_core u_core (
    .kind     (req_kind),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .funct3   (req_funct3),
    .funct7b5 (req_funct7b5),
    .imm      (req_imm),
    .word     (w_word),
    .imm_ok   (w_imm_ok)
  );

  assign req_ready = (r_state == ST_LOAD) && !r_addr_end;
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_next_addr <= '0;
      r_addr_end  <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      imm_err     <= 1'b0;
      word_count  <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state     <= ST_LOAD;
              r_next_addr <= base_addr;
              r_addr_end  <= 1'b0;
              overflow    <= 1'b0;
              imm_err     <= 1'b0;
              word_count  <= '0;
            end
          end
          ST_LOAD: begin
            if (w_accept) begin
              imem_we    <= 1'b1;
              imem_addr  <= r_next_addr;
              imem_wdata <= w_word;
              word_count <= word_count + CNT_ONE;
              if (!w_imm_ok) imm_err <= 1'b1;
              // The top address is terminal: the pointer is frozen rather than wrapped.
              if (r_next_addr == ADDR_MAX) begin
                r_addr_end <= 1'b1;
                overflow   <= 1'b1;
                r_state    <= ST_DRAIN;
              end else begin
                r_next_addr <= r_next_addr + ADDR_ONE;
                if (req_last) r_state <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            r_state <= ST_DONE;
            done    <= 1'b1;
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_encoder_loader: scoreboard bench, ADDR_W=8 and ADDR_W=4 instances.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b, abort;
  logic [7:0]  base_addr;
  logic        req_valid, req_last, req_funct7b5;
  logic [2:0]  req_kind, req_funct3;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;

  logic        req_ready_a, imem_we_a, busy_a, done_a, overflow_a, imm_err_a;
  logic [7:0]  imem_addr_a;
  logic [31:0] imem_wdata_a;
  logic [8:0]  word_count_a;
  logic        req_ready_b, imem_we_b, busy_b, done_b, overflow_b, imm_err_b;
  logic [3:0]  imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [4:0]  word_count_b;

  logic [39:0] q_a[$];
  logic [39:0] q_b[$];
  logic [39:0] pop_a, pop_b;
  logic [7:0]  exp_next_a, exp_next_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_last(req_last), .req_kind(req_kind),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3),
    .req_funct7b5(req_funct7b5), .req_imm(req_imm), .imem_we(imem_we_a), .imem_addr(imem_addr_a),
    .imem_wdata(imem_wdata_a), .busy(busy_a), .done(done_a), .overflow(overflow_a),
    .imm_err(imm_err_a), .word_count(word_count_a)
  );

  instr_encoder_loader #(.ADDR_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort), .base_addr(base_addr[3:0]),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_last(req_last), .req_kind(req_kind),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3),
    .req_funct7b5(req_funct7b5), .req_imm(req_imm), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .busy(busy_b), .done(done_b), .overflow(overflow_b),
    .imm_err(imm_err_b), .word_count(word_count_b)
  );

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every imem write must match the oldest outstanding expectation {addr, word}.
  always @(negedge clk) begin
    if (imem_we_a) begin
      if (q_a.size() == 0) check("we_unexpected_a", 40'd1, 40'd0);
      else begin
        pop_a = q_a.pop_front();
        check("write_a", {imem_addr_a, imem_wdata_a}, pop_a);
      end
    end
    if (imem_we_b) begin
      if (q_b.size() == 0) check("we_unexpected_b", 40'd1, 40'd0);
      else begin
        pop_b = q_b.pop_front();
        check("write_b", {4'h0, imem_addr_b, imem_wdata_b}, pop_b);
      end
    end
  end

  task automatic do_start(input bit to_b, input logic [7:0] base);
    base_addr = base;
    if (to_b) begin start_b = 1'b1; exp_next_b = base; end
    else      begin start_a = 1'b1; exp_next_a = base; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input string tag, input bit to_b, input logic [2:0] kind,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic f7, input logic [31:0] im,
                      input logic last, input logic [31:0] exp_word);
    bit got;
    int waits;
    req_kind = kind; req_rd = d; req_rs1 = s1; req_rs2 = s2;
    req_funct3 = f3; req_funct7b5 = f7; req_imm = im; req_last = last;
    req_valid = 1'b1;
    got = 1'b0;
    waits = -1;
    for (int i = 0; i < 8; i++) begin
      if (!got) begin
        @(negedge clk);
        if (to_b ? req_ready_b : req_ready_a) begin
          got = 1'b1;
          waits = i;
          if (to_b) begin q_b.push_back({exp_next_b, exp_word}); exp_next_b++; end
          else      begin q_a.push_back({exp_next_a, exp_word}); exp_next_a++; end
        end
      end
    end
    // Ready is expected on the first cycle offered: no bubbles between requests.
    check(tag, 40'(waits), 40'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit to_b);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!seen) begin
        @(negedge clk);
        if (to_b ? done_b : done_a) seen = 1'b1;
      end
    end
    check(tag, 40'(seen), 40'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; base_addr = 8'h00;
    req_valid = 1'b0; req_last = 1'b0; req_kind = 3'd0; req_rd = 5'd0; req_rs1 = 5'd0;
    req_rs2 = 5'd0; req_funct3 = 3'd0; req_funct7b5 = 1'b0; req_imm = 32'd0;
    exp_next_a = 8'h00; exp_next_b = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_a", 40'({imem_we_a, busy_a, done_a, req_ready_a, overflow_a, imm_err_a, word_count_a}), 40'd0);
    check("reset_b", 40'({imem_we_b, busy_b, done_b, req_ready_b, overflow_b, imm_err_b, word_count_b}), 40'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic program at 0x10; lw funct3 input is deliberately junk (forced to 010).
    do_start(1'b0, 8'h10);
    send("acc_addi", 1'b0, 3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b0, 32'h0050_0093);
    send("acc_lw",   1'b0, 3'd0, 5'd2, 5'd0, 5'd0, 3'b111, 1'b0, 32'd4, 1'b0, 32'h0040_2103);
    send("acc_sw",   1'b0, 3'd1, 5'd0, 5'd0, 5'd2, 3'b000, 1'b0, 32'd8, 1'b0, 32'h0020_2423);
    send("acc_add",  1'b0, 3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 1'b1, 32'h0020_81B3);
    wait_done("done_prog1", 1'b0);
    check("count_prog1", 40'(word_count_a), 40'd4);
    check("flags_prog1", 40'({overflow_a, imm_err_a}), 40'd0);
    @(posedge clk); #1;
    check("idle_prog1", 40'({busy_a, done_a}), 40'd0);

    // Branch/jump formats, funct7b5, and immediate-range boundaries.
    do_start(1'b0, 8'h20);
    send("acc_beq",    1'b0, 3'd3, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, -32'sd4, 1'b0, 32'hFE00_0EE3);
    send("acc_jal0",   1'b0, 3'd5, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0,   1'b0, 32'h0000_006F);
    send("acc_sub",    1'b0, 3'd2, 5'd5, 5'd6, 5'd7, 3'b000, 1'b1, 32'd0,   1'b0, 32'h4073_02B3);
    send("acc_i2048",  1'b0, 3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 1'b0, 32'h0000_0013);
    send("acc_addim1", 1'b0, 3'd4, 5'd4, 5'd4, 5'd0, 3'b000, 1'b0, -32'sd1, 1'b0, 32'hFFF2_0213);
    send("acc_jal2k",  1'b0, 3'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 1'b0, 32'h0010_00EF);
    send("acc_beqodd", 1'b0, 3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3,   1'b0, 32'h0000_0013);
    send("acc_unk",    1'b0, 3'd7, 5'd9, 5'd9, 5'd9, 3'b101, 1'b1, 32'd0,   1'b1, 32'h0000_0013);
    wait_done("done_prog2", 1'b0);
    check("count_prog2", 40'(word_count_a), 40'd8);
    check("immerr_prog2", 40'({overflow_a, imm_err_a}), 40'd1);

    // Narrow instance: top of address space ends the program early.
    do_start(1'b1, 8'h0E);
    send("acc_b0", 1'b1, 3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 1'b0, 32'h0010_0093);
    send("acc_b1", 1'b1, 3'd4, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 1'b0, 32'h0020_0113);
    req_valid = 1'b1;
    req_kind  = 3'd4;
    @(negedge clk);
    check("ready_b_end", 40'(req_ready_b), 40'd0);
    wait_done("done_b", 1'b1);
    check("ovf_b", 40'({overflow_b, word_count_b}), 40'({1'b1, 5'd2}));
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Abort coinciding with a handshake drops the write.
    do_start(1'b0, 8'h40);
    req_kind = 3'd4; req_rd = 5'd1; req_imm = 32'd7; req_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("abort_ready", 40'(req_ready_a), 40'd1);
    @(posedge clk); #1;
    abort = 1'b0; req_valid = 1'b0;
    check("abort_state", 40'({imem_we_a, busy_a, word_count_a}), 40'd0);
    @(negedge clk);
    check("abort_we", 40'(imem_we_a), 40'd0);

    // Asynchronous reset in the middle of a write.
    do_start(1'b0, 8'h50);
    send("acc_i4096", 1'b0, 3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4096, 1'b0, 32'h0000_0013);
    req_kind = 3'd4; req_rd = 5'd1; req_rs1 = 5'd0; req_imm = 32'd1; req_valid = 1'b1;
    @(negedge clk);
    check("rst_ready", 40'(req_ready_a), 40'd1);
    @(posedge clk); #1;
    check("rst_pre", 40'({imem_we_a, busy_a, imm_err_a}), 40'h7);
    reset_n = 1'b0;
    #1;
    check("rst_async", 40'({imem_we_a, busy_a, imm_err_a, req_ready_a, word_count_a}), 40'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_start(1'b0, 8'h60);
    send("acc_post", 1'b0, 3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b1, 32'h0050_0093);
    wait_done("done_post", 1'b0);
    check("count_post", 40'({imm_err_a, word_count_a}), 40'd1);

    repeat (2) @(negedge clk);
    check("sb_empty", 40'(q_a.size() + q_b.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
